pattern0_vector_sequencer: RTL

PATTERN0_VECTOR_SEQUENCER -- requirements
Module: pattern0_vector_sequencer

---
 rtl/pattern0_pkg.sv | 28 ++
 rtl/pattern0_cycle_timer.sv | 32 +++
 rtl/pattern0_vector_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pattern0_pkg.sv
// Shared encodings for the pattern0 vector sequencer: FSM states, opcodes and
// the 30-bit vector-word layout {wft[29:26], wfc[25:10], rpt[9:2], op[1:0]}.
package pattern0_pkg;

  localparam int VEC_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NORMAL     = 2'd0,
    OP_LOOP_START = 2'd1,
    OP_LOOP_END   = 2'd2,
    OP_HALT       = 2'd3
  } op_t;

  typedef struct packed {
    logic [3:0]  wft;
    logic [15:0] wfc;
    logic [7:0]  rpt;
    op_t         op;
  } vec_t;

endpackage

// File: rtl/pattern0_cycle_timer.sv
// Tester-cycle phase generator: phase counts 0..PERIOD_CYC-1 while enabled,
// sync is high for the first half of each tester cycle.
module pattern0_cycle_timer #(
  parameter int PERIOD_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tester_sync,
  output logic ph0,
  output logic ph1,
  output logic cyc_end
);

  localparam int PH_W = $clog2(PERIOD_CYC);

  logic [PH_W-1:0] phase;

  // Phase parks at 0 whenever disabled so entry into RUN always starts a fresh cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              phase <= '0;
    else if (!en)                            phase <= '0;
    else if (phase == PH_W'(PERIOD_CYC - 1)) phase <= '0;
    else                                     phase <= phase + PH_W'(1);
  end

  assign tester_sync = en && (phase < PH_W'(PERIOD_CYC / 2));
  assign ph0         = en && (phase == '0);
  assign ph1         = en && (phase == PH_W'(1));
  assign cyc_end     = en && (phase == PH_W'(PERIOD_CYC - 1));

endmodule

// File: rtl/pattern0_vector_sequencer.sv
// Vector-memory sequencer: fetches vectors, repeats/loops them per opcode and
// presents wft/wfc plus a tester-cycle strobe to the timing-control stage.
module pattern0_vector_sequencer
  import pattern0_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int PERIOD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VEC_W-1:0]  mem_rdata,
  output logic              tester_sync,
  output logic [3:0]        wft,
  output logic [15:0]       wfc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       vec_count
);

  state_t            state, state_nxt;
  vec_t              pf, ld_vec;
  logic [3:0]        cur_wft;
  logic [15:0]       cur_wfc;
  logic [7:0]        rpt_cnt, loop_cnt, le_cnt;
  logic [ADDR_W-1:0] loop_addr, nxt_addr;
  logic              fetch_wait, loop_active, wrap_pend, le_branch;
  logic              in_run, ts_raw, ph0, ph1, cyc_end;
  logic              start_ok, load_vec, run_vec, repeat_cyc, set_err;

  pattern0_cycle_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (in_run),
    .tester_sync (ts_raw),
    .ph0         (ph0),
    .ph1         (ph1),
    .cyc_end     (cyc_end)
  );

  // The first vector comes straight off the memory bus; later ones from the prefetch.
  assign ld_vec    = (state == ST_FETCH) ? vec_t'(mem_rdata) : pf;
  assign le_cnt    = loop_active ? loop_cnt : ld_vec.rpt;
  assign le_branch = (ld_vec.op == OP_LOOP_END) && (le_cnt != 8'd0);
  assign nxt_addr  = le_branch ? loop_addr : mem_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    load_vec   = 1'b0;
    repeat_cyc = 1'b0;
    set_err    = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state_nxt = ST_FETCH;
          start_ok  = 1'b1;
        end
        ST_FETCH: if (!fetch_wait) load_vec = 1'b1;
        ST_RUN: if (cyc_end) begin
          if (rpt_cnt != 8'd0)  repeat_cyc = 1'b1;
          else if (wrap_pend) begin
            set_err   = 1'b1;
            state_nxt = ST_DONE;
          end else              load_vec = 1'b1;
        end
        ST_DONE: begin
          state_nxt = start ? ST_FETCH : ST_IDLE;
          start_ok  = start;
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (load_vec) state_nxt = (ld_vec.op == OP_HALT) ? ST_DONE : ST_RUN;
    end
    run_vec = load_vec && (ld_vec.op != OP_HALT);
  end

  always_comb begin
    in_run      = (state == ST_RUN);
    busy        = (state == ST_FETCH) || in_run;
    done        = (state == ST_DONE);
    tester_sync = ts_raw;
    wft         = in_run ? cur_wft : 4'd0;
    wfc         = in_run ? cur_wfc : 16'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      loop_addr   <= '0;
      pf          <= '0;
      cur_wft     <= '0;
      cur_wfc     <= '0;
      rpt_cnt     <= '0;
      loop_cnt    <= '0;
      loop_active <= 1'b0;
      wrap_pend   <= 1'b0;
      fetch_wait  <= 1'b0;
      err         <= 1'b0;
      vec_count   <= '0;
    end else if (start_ok) begin
      mem_addr    <= '0;
      loop_addr   <= '0;
      loop_cnt    <= '0;
      loop_active <= 1'b0;
      wrap_pend   <= 1'b0;
      fetch_wait  <= 1'b1;
      err         <= 1'b0;
      vec_count   <= '0;
    end else begin
      if (state == ST_FETCH) fetch_wait <= 1'b0;
      if (ph1)               pf <= vec_t'(mem_rdata);
      if (set_err)           err <= 1'b1;
      if (repeat_cyc)        rpt_cnt <= rpt_cnt - 8'd1;
      if (ph0 && vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
      if (run_vec) begin
        cur_wft   <= ld_vec.wft;
        cur_wfc   <= ld_vec.wfc;
        rpt_cnt   <= (ld_vec.op == OP_LOOP_END) ? 8'd0 : ld_vec.rpt;
        mem_addr  <= nxt_addr;
        // Falling off the top of memory is only an error once this vector has finished.
        wrap_pend <= !le_branch && (mem_addr == '1);
        if (ld_vec.op == OP_LOOP_START) loop_addr <= mem_addr;
        if (ld_vec.op == OP_LOOP_END) begin
          loop_active <= le_branch;
          loop_cnt    <= le_branch ? le_cnt - 8'd1 : 8'd0;
        end
      end
    end
  end

endmodule
